spi_tx_fifo: RTL



---
 rtl/spi_tx_fifo.sv | 125 ++++++++++++
 1 files changed

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: first-word-fall-through FIFO for 9-bit SPI transmit words
// ({dc, data[7:0]}). It sits directly upstream of spi_master and absorbs
// bursts from a CPU or sequencer so they do not wait on serial shifting.
//
// Ports:
//   reset      async reset, active-high
//   clock      single clock for both sides
//   in         write word ({dc, data})
//   put        write strobe, one word per clock while high
//   full       no free entries
//   out        head word, forced to 0 while empty
//   get        pop strobe, one word per clock while high
//   empty      no stored entries
//   overflow   sticky: a put was dropped
//   underflow  sticky: a get was issued while empty
//   level        (SPI_TX_FIFO_LEVEL_EN only) current entry count
//   almost_full  (SPI_TX_FIFO_LEVEL_EN only) count >= DEPTH-AF_MARGIN
//
// Optional feature macro: SPI_TX_FIFO_LEVEL_EN
module spi_tx_fifo #(
  parameter int unsigned WIDTH     = 9,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic                     reset,
  input  logic                     clock,
  input  logic [WIDTH-1:0]         in,
  input  logic                     put,
  output logic                     full,
  output logic [WIDTH-1:0]         out,
  input  logic                     get,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
`ifdef SPI_TX_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Reject unusable configurations at elaboration
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AF_MARGIN > DEPTH) begin : g_bad_params
    $error("spi_tx_fifo: DEPTH must be a power of two >= 2 and AF_MARGIN <= DEPTH");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_do_get;
  logic             w_do_put;
  logic [CW-1:0]    w_count_nxt;

  // A pop while full frees a slot on the same edge, so the put is accepted too
  assign w_do_get = get & ~r_empty;
  assign w_do_put = put & (~r_full | w_do_get);

  // Next occupancy
  always_comb begin
    w_count_nxt = r_count;
    if (w_do_put && !w_do_get) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_do_put && w_do_get) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Pointers, occupancy, flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_do_put) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_get) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      if (put && !w_do_put) r_overflow  <= 1'b1;
      if (get && r_empty)   r_underflow <= 1'b1;
    end
  end

  // Storage; contents are not cleared by reset
  always_ff @(posedge clock) begin
    if (w_do_put) r_mem[r_wr_ptr] <= in;
  end

  assign full      = r_full;
  assign empty     = r_empty;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign out       = r_empty ? '0 : r_mem[r_rd_ptr];

`ifdef SPI_TX_FIFO_LEVEL_EN
  logic r_almost_full;

  // Early-warning flag so the producer can throttle before full
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_count_nxt >= CW'(DEPTH - AF_MARGIN));
    end
  end

  assign level       = r_count;
  assign almost_full = r_almost_full;
`endif

endmodule
